// File: rtl/add_seq_ctrl_pkg.sv
// Shared ALU package: adder width, sequencer FSM states and requester id type.
package add_seq_ctrl_pkg;

    localparam int CLA_W = 17;
    localparam int K_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } add_seq_state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/add_seq_ctrl_arb.sv
// Two-way round-robin arbiter with a registered last_grant (resets to 1).
module add_seq_rr_arb
    import add_seq_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] gnt,
    output req_id_t    gnt_id
);

    req_id_t last_grant_q;
    req_id_t last_grant_d;

    always_comb begin
        gnt_id       = 1'b0;
        gnt          = 2'b00;
        last_grant_d = last_grant_q;
        unique case (1'b1)
            (req == 2'b11): gnt_id = ~last_grant_q;
            (req == 2'b10): gnt_id = 1'b1;
            default:        gnt_id = 1'b0;
        endcase
        if (req != 2'b00) begin
            gnt = gnt_id ? 2'b10 : 2'b01;
        end
        if (accept) begin
            last_grant_d = gnt_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/cla_17.sv
// 17-bit carry-lookahead adder; cout = {carry out, carry into bit 16, carry into bit 8}.
module cla_17
    import add_seq_ctrl_pkg::*;
(
    input  logic [CLA_W-1:0] op_a,
    input  logic [CLA_W-1:0] op_b,
    input  logic             cin,
    output logic [CLA_W-1:0] sum,
    output logic [2:0]       cout
);

    logic [CLA_W-1:0] g;
    logic [CLA_W-1:0] p;
    logic [CLA_W:0]   c;

    // Generate/propagate prefix; synthesis flattens this into lookahead terms.
    always_comb begin
        g    = op_a & op_b;
        p    = op_a ^ op_b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < CLA_W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        sum  = p ^ c[CLA_W-1:0];
        cout = {c[CLA_W], c[CLA_W-1], c[8]};
    end

endmodule

// File: rtl/add_seq_ctrl.sv
// Multi-precision add/sub sequencer sharing one cla_17 between two requesters.
// Subtraction support is built only when ADD_SEQ_SUB_EN is defined.
module add_seq_ctrl
    import add_seq_ctrl_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   r0_valid,
    output logic                   r0_ready,
    input  logic [CLA_W*WORDS-1:0] r0_a,
    input  logic [CLA_W*WORDS-1:0] r0_b,
    input  logic                   r0_sub,
    input  logic                   r1_valid,
    output logic                   r1_ready,
    input  logic [CLA_W*WORDS-1:0] r1_a,
    input  logic [CLA_W*WORDS-1:0] r1_b,
    input  logic                   r1_sub,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [CLA_W*WORDS-1:0] rsp_sum,
    output logic                   rsp_carry,
    output logic                   rsp_ovf,
    output logic                   busy
);

    localparam int N = CLA_W * WORDS;

    add_seq_state_t state_q, state_d;
    logic [K_W-1:0] k_q, k_d;
    logic           carry_q, carry_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   res_q, res_d;
    req_id_t        id_q, id_d;
    logic           rc_q, rc_d;
    logic           ovf_q, ovf_d;

    logic [1:0]       req;
    logic [1:0]       gnt;
    req_id_t          gnt_id;
    logic             fire;
    logic             sel_sub;
    logic [N-1:0]     sel_a;
    logic [N-1:0]     sel_b;
    logic [CLA_W-1:0] op_a;
    logic [CLA_W-1:0] op_b;
    logic [CLA_W-1:0] sum;
    logic [2:0]       cout;
    logic             unused_cout0;

    assign req  = {r1_valid, r0_valid} & {2{state_q == ST_IDLE}};
    assign fire = |gnt;

    add_seq_rr_arb u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .accept (fire),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign sel_a = gnt_id ? r1_a : r0_a;
    assign sel_b = gnt_id ? r1_b : r0_b;

`ifdef ADD_SEQ_SUB_EN
    assign sel_sub = gnt_id ? r1_sub : r0_sub;
`else
    logic unused_sub;
    assign unused_sub = r0_sub ^ r1_sub;
    assign sel_sub    = 1'b0;
`endif

    assign op_a = a_q[k_q*CLA_W +: CLA_W];
    assign op_b = b_q[k_q*CLA_W +: CLA_W];

    cla_17 u_cla (
        .op_a (op_a),
        .op_b (op_b),
        .cin  (carry_q),
        .sum  (sum),
        .cout (cout)
    );

    assign unused_cout0 = cout[0];

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        id_d    = id_q;
        rc_d    = rc_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    a_d     = sel_a;
`ifdef ADD_SEQ_SUB_EN
                    b_d     = sel_sub ? ~sel_b : sel_b;
`else
                    b_d     = sel_b;
`endif
                    carry_d = sel_sub;
                    id_d    = gnt_id;
                    k_d     = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d[k_q*CLA_W +: CLA_W] = sum;
                carry_d = cout[2];
                k_d     = k_q + 1'b1;
                if (k_q == K_W'(WORDS - 1)) begin
                    rc_d    = cout[2];
                    ovf_d   = cout[2] ^ cout[1];
                    k_d     = '0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            id_q    <= 1'b0;
            rc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            id_q    <= id_d;
            rc_q    <= rc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign r0_ready  = gnt[0];
    assign r1_ready  = gnt[1];
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_id    = id_q;
    assign rsp_sum   = res_q;
    assign rsp_carry = rc_q;
    assign rsp_ovf   = ovf_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Scoreboard bench for add_seq_ctrl: accepts push reference results,
// a monitor pops and compares each response.
module tb_add_seq_ctrl;
    import add_seq_ctrl_pkg::*;

    localparam int W = 4;
    localparam int N = CLA_W * W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         r0_valid = 1'b0, r1_valid = 1'b0;
    logic         r0_ready, r1_ready;
    logic [N-1:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
    logic         r0_sub = 1'b0, r1_sub = 1'b0;
    logic         rsp_valid, rsp_id, rsp_carry, rsp_ovf, busy;
    logic         rsp_ready = 1'b1;
    logic [N-1:0] rsp_sum;

    add_seq_ctrl #(.WORDS(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_valid(r0_valid), .r0_ready(r0_ready),
        .r0_a(r0_a), .r0_b(r0_b), .r0_sub(r0_sub),
        .r1_valid(r1_valid), .r1_ready(r1_ready),
        .r1_a(r1_a), .r1_b(r1_b), .r1_sub(r1_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum),
        .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         id;
        logic [N-1:0] sum;
        logic         c;
        logic         v;
        int           acc;
    } exp_t;

    exp_t         sb[$];
    int           id_log[$];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           acc_cnt = 0;
    int           rsp_cnt = 0;
    int           hs_edge = 0;
    bit           in_rsp = 0;
    bit           resume_chk = 0;
    bit           mlast = 1;
    logic         hold_id, hold_c, hold_v;
    logic [N-1:0] hold_sum;
    logic         last_id, last_c, last_v;
    logic [N-1:0] last_sum;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [N-1:0] act,
                       input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [N-1:0] rnd();
        logic [N-1:0] r;
        for (int i = 0; i < N; i += 32) r = {r[N-1:0], 32'($urandom)};
        return r;
    endfunction

    // Reference: plain modular arithmetic with signed-overflow rule.
    function automatic exp_t model(input logic id, input logic [N-1:0] a,
                                   input logic [N-1:0] b, input logic sub);
        exp_t e;
        logic [N:0] full;
        e.id = id;
        e.acc = 0;
        full = {1'b0, a} + {1'b0, b};
        e.sum = full[N-1:0];
        e.c = full[N];
        e.v = (a[N-1] == b[N-1]) && (e.sum[N-1] != a[N-1]);
`ifdef ADD_SEQ_SUB_EN
        if (sub) begin
            e.sum = a - b;
            e.c = (a >= b);
            e.v = (a[N-1] != b[N-1]) && (e.sum[N-1] != a[N-1]);
        end
`else
        if (sub) e.id = id;
`endif
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            sb.delete();
            in_rsp = 0;
            mlast = 1;
        end else begin
            if (r0_ready && r1_ready) chk("both_ready", 1, 0);
            if (rsp_valid) chk("ready_in_done", {r1_ready, r0_ready}, 0);
            for (int i = 0; i < 2; i++) begin
                if ((i == 0) ? (r0_valid && r0_ready) : (r1_valid && r1_ready)) begin
                    if (r0_valid && r1_valid) chk("arb_rr", i, !mlast);
                    if (resume_chk) begin
                        chk("resume_edge", cyc + 1, hs_edge + 1);
                        resume_chk = 0;
                    end
                    e = (i == 0) ? model(0, r0_a, r0_b, r0_sub)
                                 : model(1, r1_a, r1_b, r1_sub);
                    e.acc = cyc + 1;
                    sb.push_back(e);
                    id_log.push_back(i);
                    mlast = (i != 0);
                    acc_cnt++;
                end
            end
            if (rsp_valid) begin
                if (!in_rsp) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got sum %h expected none", rsp_sum);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_id", rsp_id, e.id);
                        chk("rsp_sum", rsp_sum, e.sum);
                        chk("rsp_carry", rsp_carry, e.c);
                        chk("rsp_ovf", rsp_ovf, e.v);
                        chk("latency", cyc, e.acc + W);
                    end
                    hold_id = rsp_id; hold_sum = rsp_sum;
                    hold_c = rsp_carry; hold_v = rsp_ovf;
                    in_rsp = 1;
                end else begin
                    chk("hold_sum", rsp_sum, hold_sum);
                    chk("hold_flags", {rsp_id, rsp_carry, rsp_ovf},
                        {hold_id, hold_c, hold_v});
                end
                if (rsp_ready) begin
                    in_rsp = 0;
                    hs_edge = cyc + 1;
                    last_id = rsp_id; last_sum = rsp_sum;
                    last_c = rsp_carry; last_v = rsp_ovf;
                    rsp_cnt++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int target, input string nm);
        int n;
        n = 0;
        while (acc_cnt < target && n < 100) begin
            step();
            n++;
        end
        if (acc_cnt < target) chk({nm, "_accept_timeout"}, acc_cnt, target);
    endtask

    task automatic issue(input int who, input logic [N-1:0] a,
                         input logic [N-1:0] b, input logic sub);
        if (who == 0) begin r0_a = a; r0_b = b; r0_sub = sub; r0_valid = 1; end
        else begin r1_a = a; r1_b = b; r1_sub = sub; r1_valid = 1; end
        wait_acc(acc_cnt + 1, "issue");
        r0_valid = 0;
        r1_valid = 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        r0_valid = 0;
        r1_valid = 0;
        rsp_ready = 1;
        while ((sb.size() != 0 || rsp_valid || busy) && n < 200) begin
            step();
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_valid"}, rsp_valid, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_sum"}, rsp_sum, 0);
        chk({nm, "_flags"}, {rsp_id, rsp_carry, rsp_ovf}, 0);
        chk({nm, "_readies"}, {r1_ready, r0_ready}, 0);
    endtask

    initial begin
        logic [N-1:0] ones;
        int base;
        ones = '1;
        #2;
        check_reset_outputs("reset");
        step();
        step();
        rst_n = 1;
        step();

        issue(0, ones, 1, 0);
        drain();
        chk("ripple_sum", last_sum, 0);
        chk("ripple_flags", {last_id, last_c, last_v}, 3'b010);

        issue(0, ones >> 1, 1, 0);
        drain();
        chk("ovf_sum", last_sum, ~(ones >> 1));
        chk("ovf_flags", {last_c, last_v}, 2'b01);

        issue(1, 5, 7, 1);
        drain();
`ifdef ADD_SEQ_SUB_EN
        chk("sub_sum", last_sum, ones - 1);
        chk("sub_flags", {last_id, last_c, last_v}, 3'b100);
`else
        chk("sub_ignored_sum", last_sum, 12);
`endif

        // Arbitration straight after reset: ties go r0, r1, r0, r1.
        rst_n = 0;
        step();
        rst_n = 1;
        step();
        base = id_log.size();
        r0_valid = 1;
        r1_valid = 1;
        rsp_ready = 1;
        while (id_log.size() < base + 4 && acc_cnt < base + 100) begin
            r0_a = rnd(); r0_b = rnd(); r0_sub = 1'($urandom);
            r1_a = rnd(); r1_b = rnd(); r1_sub = 1'($urandom);
            wait_acc(acc_cnt + 1, "arb");
        end
        for (int i = 0; i < 4; i++) chk("grant_order", id_log[base + i], i % 2);
        drain();

        // Backpressure: five held DONE cycles, then accept resumes.
        rsp_ready = 0;
        issue(0, rnd(), rnd(), 0);
        r0_valid = 1;
        r1_valid = 1;
        for (int n = 0; n < 50 && !rsp_valid; n++) step();
        chk("bp_valid_seen", rsp_valid, 1);
        repeat (5) step();
        resume_chk = 1;
        rsp_ready = 1;
        wait_acc(acc_cnt + 1, "resume");
        drain();

        // Randomized traffic with random response backpressure.
        for (int n = 0; n < 300; n++) begin
            r0_valid = 1'($urandom);
            r1_valid = 1'($urandom);
            r0_a = rnd(); r0_b = rnd(); r0_sub = 1'($urandom);
            r1_a = rnd(); r1_b = rnd(); r1_sub = 1'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        // Reset in the middle of RUN at word 2.
        rsp_ready = 1;
        issue(0, rnd(), rnd(), 0);
        step();
        step();
        chk("busy_mid_run", busy, 1);
        rst_n = 0;
        #1;
        check_reset_outputs("mid_reset");
        @(negedge clk);
        step();
        rst_n = 1;
        base = id_log.size();
        r0_a = rnd(); r0_b = rnd();
        r1_a = rnd(); r1_b = rnd();
        r0_valid = 1;
        r1_valid = 1;
        wait_acc(acc_cnt + 1, "post_reset");
        r0_valid = 0;
        r1_valid = 0;
        if (id_log.size() > base) chk("post_reset_grant", id_log[base], 0);
        drain();
        chk("rsp_count", rsp_cnt > 20, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/add_seq_ctrl.md
# add_seq_ctrl

Multi-precision add/subtract sequencer that shares one 17-bit carry-lookahead adder (`cla_17`) between two requesters. It accepts WORDS×17-bit operand pairs, arbitrates round-robin, and feeds the adder one 17-bit word per cycle, least-significant word (LSW) first, chaining the carry. It returns the wide sum with carry-out and signed-overflow flags over a valid/ready response port. It sits in the ALU between the issue logic and the shared adder datapath.

## Interface
- `WORDS`, default 4: number of 17-bit words per operand (68-bit); legal range 1..16.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `r0_valid` / `r1_valid`  in  1  request valid, requester 0 / 1.
- `r0_ready` / `r1_ready`  out  1  request accepted this cycle when the matching valid is also high.
- `r0_a`, `r0_b` / `r1_a`, `r1_b`  in  17*WORDS  operands.
- `r0_sub` / `r1_sub`  in  1  1 = compute a−b (honoured only with `ADD_SEQ_SUB_EN`).
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer takes the result.
- `rsp_id`  out  1  requester index of the result.
- `rsp_sum`  out  17*WORDS  result.
- `rsp_carry`  out  1  carry out of the MSW. For subtract, 1 = no borrow.
- `rsp_ovf`  out  1  signed overflow.
- `busy`  out  1  state ≠ IDLE.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - Round-robin arbiter selects among the valid requesters. When both are valid, the one not granted last wins.
  - `last_grant` resets to 1, so r0 wins the first tie.
  - Ready is asserted combinationally for the selected requester only. This is a valid→ready combinational path and is allowed.
- **Accept (valid && ready):**
  - Latch a, b, sub and id.
  - Word index k ← 0.
  - Carry register ← sub.
  - b is latched inverted when sub = 1.
  - Update `last_grant`; go to RUN.
- **RUN, each cycle:**
  - Drive the adder with op_a = a[k], op_b = b[k], cin = carry.
  - Write sum into result slice k.
  - carry ← `cout[2]` (bit-17 carry).
  - k ← k+1.
- **Last word (k = WORDS−1):**
  - `rsp_carry` ← `cout[2]`.
  - `rsp_ovf` ← `cout[2]` XOR `cout[1]` (carry into vs. out of bit 16 of the MSW).
  - Go to DONE.
- **DONE:** `rsp_valid` = 1 and all response outputs are held stable until `rsp_ready`; then go to IDLE. No request is accepted in RUN or DONE.
- **Upper-word slices:** `rsp_sum` slices for words not yet computed hold the previous result until overwritten. `rsp_sum` is valid only while `rsp_valid` is high.
- **Reset (any state, including mid-RUN):**
  - Return to IDLE and drop any in-flight operation.
  - `rsp_valid`, `rsp_id`, `rsp_sum`, `rsp_carry`, `rsp_ovf`, `busy` = 0.
  - `last_grant` = 1; k = 0; carry = 0.
  - Readies follow the IDLE rule, so they are 0 with no valid.
- **Request inputs:** changes to requester inputs after accept have no effect.

## Timing
- Accept at edge E0. Word k is computed in the cycle after edge E0+k and registered at edge E0+k+1.
- `rsp_valid` rises at edge E0+WORDS: latency is WORDS cycles from accept.
- With `rsp_ready` = 1 on the first DONE cycle, the FSM returns to IDLE at the next edge. The earliest next accept is at that IDLE cycle.
- Throughput: one operation per WORDS+2 cycles.
- WORDS = 1: a single RUN cycle; behaviour is otherwise identical.

## Configuration
- **`ADD_SEQ_SUB_EN` defined:** `rX_sub` honoured. Subtraction is implemented as two's complement (b inverted, cin = 1).
- **`ADD_SEQ_SUB_EN` undefined:** `rX_sub` ports remain but are ignored; all operations are add with cin = 0; no inversion logic is built.

## Structure
- **Shared ALU package:**
  - Width constant `CLA_W` = 17.
  - FSM state enum `add_seq_state_t`.
  - Requester-id type.
- **Sub-modules:**
  - `cla_17` is instantiated once as the datapath.
  - The round-robin arbiter is the one natural sub-module: `add_seq_rr_arb`, 2 requesters, registered `last_grant`.

## Test plan
- **Add with full carry ripple:** WORDS = 4, r0 add, a = 2^68−1, b = 1 → `rsp_sum` = 0, `rsp_carry` = 1, `rsp_ovf` = 0, `rsp_id` = 0, `rsp_valid` exactly 4 cycles after accept.
- **Signed overflow:** a = 2^67−1, b = 1 → `rsp_sum` = 2^67, `rsp_carry` = 0, `rsp_ovf` = 1.
- **Subtract** (`ADD_SEQ_SUB_EN`): a = 5, b = 7, sub = 1 → `rsp_sum` = 2^68−2, `rsp_carry` = 0, `rsp_ovf` = 0. With the macro undefined, the same stimulus → `rsp_sum` = 12.
- **Arbitration:** r0 and r1 valid continuously, `rsp_ready` = 1 → grants r0, r1, r0, r1 in order; each `rsp_id` matches its grant.
- **Backpressure:** `rsp_ready` held 0 for 5 DONE cycles → `rsp_valid`, `rsp_sum` and flags stable; `r0_ready`/`r1_ready` remain 0; accept resumes one cycle after the handshake.
- **Reset mid-operation:** assert `rst_n` low during RUN (k = 2) → all outputs 0 and `busy` = 0 immediately. After release, the first tie is granted to r0 and runs from k = 0.
